// File: rtl/myriadrf_pkg.sv
// Shared constants for the MyriadRF receive path.
// Used by the RX interface, RX FIFO and DMA blocks.
package myriadrf_pkg;

    localparam int MYRIADRF_IQ_W     = 12;
    localparam int MYRIADRF_SAMPLE_W = 24;
    localparam int MYRIADRF_FIFO_AW  = 4;
    localparam int MYRIADRF_PKT_LEN  = 256;
    localparam int MYRIADRF_DROP_CW  = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int myriadrf_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/myriadrf_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Head entry is read combinationally; occupancy is tracked explicitly.
module myriadrf_sync_fifo #(
    parameter int W  = 25,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == DEPTH);
    assign o_level = r_level;

endmodule

// File: rtl/myriadrf_rx_fifo.sv
// RX sample buffer: accept/drop control, packet-end tagging and
// overflow statistics around a FWFT FIFO.
module myriadrf_rx_fifo
    import myriadrf_pkg::*;
#(
    parameter int DW      = MYRIADRF_SAMPLE_W,
    parameter int AW      = MYRIADRF_FIFO_AW,
    parameter int PKT_LEN = MYRIADRF_PKT_LEN,
    parameter int CW      = MYRIADRF_DROP_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_last_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          ovf_o,
    input  logic          ovf_clr_i,
    output logic [CW-1:0] drop_cnt_o,
    output logic [AW:0]   level_o
);

    localparam int IW = myriadrf_idx_w(PKT_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(PKT_LEN - 1);

    logic [IW-1:0] r_pkt_idx;
    logic          r_ovf;
    logic [CW-1:0] r_drop_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic          w_drop;
    logic          w_tag_last;
    logic          w_empty;
    logic          w_full;
    logic [DW:0]   w_rdata;

    assign w_push     = s_valid_i & en_i;
    assign w_pop      = ~w_empty & m_ready_i;
    // A full FIFO still takes a sample when the head leaves this cycle
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & ~w_accept;
    assign w_tag_last = (r_pkt_idx == IDX_LAST);

    myriadrf_sync_fifo #(
        .W  (DW + 1),
        .AW (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_wdata ({w_tag_last, s_data_i}),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (level_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_idx <= '0;
        end else if (!en_i) begin
            r_pkt_idx <= '0;
        end else if (w_accept) begin
            r_pkt_idx <= w_tag_last ? '0 : r_pkt_idx + 1'b1;
        end
    end

    // A drop in the clearing cycle counts as the first of a new run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr_i)
                r_drop_cnt <= CW'(1);
            else if (!(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + CW'(1);
        end else if (ovf_clr_i) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign m_valid_o  = ~w_empty;
    assign m_data_o   = w_rdata[DW-1:0];
    assign m_last_o   = w_rdata[DW] & ~w_empty;
    assign ovf_o      = r_ovf;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_myriadrf_rx_fifo.sv
// Self-checking bench for myriadrf_rx_fifo: vector table, directed
// corner sequences and a queue-based reference model.
module tb_myriadrf_rx_fifo;

    localparam int DW = 24;
    localparam int AW = 4;
    localparam int PL = 4;
    localparam int CW = 3;
    localparam int DEPTH = 16;
    localparam int CMAX = 7;

    logic          clk;
    logic          rst_n;
    logic          en_i;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          ovf_o;
    logic          ovf_clr_i;
    logic [CW-1:0] drop_cnt_o;
    logic [AW:0]   level_o;

    myriadrf_rx_fifo #(
        .DW(DW), .AW(AW), .PKT_LEN(PL), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i),
        .drop_cnt_o (drop_cnt_o),
        .level_o    (level_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW:0] mq[$];
    int m_idx = 0;
    int m_cnt = 0;
    bit m_ovf = 0;

    // Observation log
    bit          rec = 0;
    int          out_n = 0;
    int          last_pos[$];
    logic [DW-1:0] popped[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        bit acc;
        bit lst;
        if (!rst_n) begin
            mq.delete();
            m_idx = 0;
            m_cnt = 0;
            m_ovf = 0;
            return;
        end
        pop  = (mq.size() > 0) && m_ready_i;
        push = s_valid_i && en_i;
        acc  = push && ((mq.size() < DEPTH) || pop);
        lst  = (m_idx == PL - 1);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back({lst, s_data_i});
            m_idx = lst ? 0 : m_idx + 1;
        end
        if (!en_i) m_idx = 0;
        if (push && !acc) begin
            m_ovf = 1;
            m_cnt = ovf_clr_i ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        end else if (ovf_clr_i) begin
            m_ovf = 0;
            m_cnt = 0;
        end
    endtask

    task automatic model_cmp();
        int sz;
        sz = mq.size();
        chk("valid", 32'(m_valid_o), 32'(sz != 0));
        chk("level", 32'(level_o), 32'(sz));
        chk("last", 32'(m_last_o), sz != 0 ? 32'(mq[0][DW]) : 32'd0);
        if (sz != 0) chk("data", 32'(m_data_o), 32'(mq[0][DW-1:0]));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt_o), 32'(m_cnt));
    endtask

    task automatic cyc();
        if (rec && m_valid_o && m_ready_i) begin
            out_n++;
            if (m_last_o) last_pos.push_back(out_n);
            popped.push_back(m_data_o);
        end
        model_step();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic r, input logic c);
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = r;
        ovf_clr_i = c;
    endtask

    typedef struct {
        logic          rst_n;
        logic          en;
        logic          vld;
        logic [DW-1:0] d;
        logic          rdy;
        logic          clr;
        logic          ev;
        logic [DW-1:0] ed;
        logic [AW:0]   el;
        logic          eovf;
        logic [CW-1:0] ecnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        int acc_n;
        int cyc_n;
        rst_n = 1'b0;
        en_i  = 1'b1;
        drive(1'b1, 24'h111111, 1'b0, 1'b0);

        vt[0] = '{1'b0, 1'b1, 1'b1, 24'h111111, 1'b0, 1'b0,
                  1'b0, 24'h0, 5'd0, 1'b0, 3'd0};
        vt[1] = vt[0];
        vt[2] = vt[0];
        vt[3] = '{1'b1, 1'b0, 1'b1, 24'h222222, 1'b0, 1'b0,
                  1'b0, 24'h0, 5'd0, 1'b0, 3'd0};
        vt[4] = vt[3];
        vt[5] = '{1'b1, 1'b1, 1'b1, 24'hABC123, 1'b0, 1'b0,
                  1'b1, 24'hABC123, 5'd1, 1'b0, 3'd0};
        vt[6] = '{1'b1, 1'b1, 1'b0, 24'h555555, 1'b0, 1'b0,
                  1'b1, 24'hABC123, 5'd1, 1'b0, 3'd0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 24'h0, 1'b1, 1'b0,
                  1'b0, 24'h0, 5'd0, 1'b0, 3'd0};

        // Reset, idle and single sample
        for (int i = 0; i < 8; i++) begin
            rst_n = vt[i].rst_n;
            en_i  = vt[i].en;
            drive(vt[i].vld, vt[i].d, vt[i].rdy, vt[i].clr);
            cyc();
            chk($sformatf("vec%0d_valid", i), 32'(m_valid_o), 32'(vt[i].ev));
            chk($sformatf("vec%0d_level", i), 32'(level_o), 32'(vt[i].el));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_o), 32'(vt[i].eovf));
            chk($sformatf("vec%0d_cnt", i), 32'(drop_cnt_o), 32'(vt[i].ecnt));
            if (vt[i].ev)
                chk($sformatf("vec%0d_data", i), 32'(m_data_o), 32'(vt[i].ed));
        end

        // Packet tagging: fresh packet, 10 samples streamed out
        en_i = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        en_i = 1'b1;
        rec = 1; out_n = 0; last_pos.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(i + 1), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cyc();
        chk("pkt_outs", 32'(out_n), 32'd10);
        chk("pkt_nlast", 32'(last_pos.size()), 32'd2);
        if (last_pos.size() == 2) begin
            chk("pkt_last0", 32'(last_pos[0]), 32'd4);
            chk("pkt_last1", 32'(last_pos[1]), 32'd8);
        end

        // Disable one cycle (sample ignored), then a new packet of 4
        en_i = 1'b0;
        drive(1'b1, 24'hDEAD00, 1'b1, 1'b0);
        cyc();
        chk("en0_nodrop", 32'(drop_cnt_o), 32'd0);
        en_i = 1'b1;
        out_n = 0; last_pos.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(24'h100 + i), 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cyc();
        chk("pkt2_outs", 32'(out_n), 32'd4);
        chk("pkt2_nlast", 32'(last_pos.size()), 32'd1);
        if (last_pos.size() == 1) chk("pkt2_last", 32'(last_pos[0]), 32'd4);
        rec = 0;

        // Reset mid-operation discards buffered data
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(24'h777000 + i), 1'b0, 1'b0);
            cyc();
        end
        chk("pre_rst_level", 32'(level_o), 32'd5);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_level", 32'(level_o), 32'd0);
        chk("mid_rst_valid", 32'(m_valid_o), 32'd0);
        rst_n = 1'b1;

        // Overflow: 20 pushes into 16 entries
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            cyc();
        end
        chk("ovf_level", 32'(level_o), 32'd16);
        chk("ovf_flag", 32'(ovf_o), 32'd1);
        chk("ovf_cnt", 32'(drop_cnt_o), 32'd4);

        // 21st push alongside a pop is accepted
        rec = 1; popped.delete(); out_n = 0;
        drive(1'b1, DW'(21), 1'b1, 1'b0);
        cyc();
        chk("full_pop_cnt", 32'(drop_cnt_o), 32'd4);
        chk("full_pop_level", 32'(level_o), 32'd16);

        // Drop coinciding with clear, then clear alone
        drive(1'b1, DW'(22), 1'b0, 1'b1);
        cyc();
        chk("race_cnt", 32'(drop_cnt_o), 32'd1);
        chk("race_ovf", 32'(ovf_o), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        cyc();
        chk("clr_cnt", 32'(drop_cnt_o), 32'd0);
        chk("clr_ovf", 32'(ovf_o), 32'd0);

        // Saturation of the 3-bit drop counter
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(24'hF00 + i), 1'b0, 1'b0);
            cyc();
        end
        chk("sat_cnt", 32'(drop_cnt_o), 32'd7);
        chk("sat_ovf", 32'(ovf_o), 32'd1);

        // Drain and check order: 1..16, then 21
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (18) cyc();
        rec = 0;
        chk("drain_n", 32'(popped.size()), 32'd17);
        if (popped.size() == 17) begin
            for (int i = 0; i < 16; i++)
                chk($sformatf("drain%0d", i), 32'(popped[i]), 32'(i + 1));
            chk("drain16", 32'(popped[16]), 32'd21);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        cyc();

        // Random streaming across pointer wrap
        acc_n = 0;
        cyc_n = 0;
        while (acc_n < 100 && cyc_n < 2000) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'b0);
            if (s_valid_i && (mq.size() < DEPTH ||
                (mq.size() > 0 && m_ready_i))) acc_n++;
            cyc();
            cyc_n++;
        end
        chk("rand_done", 32'(acc_n), 32'd100);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (20) cyc();
        chk("rand_empty", 32'(level_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/myriadrf_rx_fifo.md
Name: myriadrf_rx_fifo

Overview:
- Sits directly downstream of the MyriadRF RX interface.
- Accepts one 24-bit packed IQ sample per valid cycle, {Q[23:12], I[11:0]}; there is no backpressure on the sample input.
- Buffers samples in a small synchronous FIFO and presents them to the DMA/bus side on a valid/ready stream.
- Tags every PKT_LEN-th accepted sample as packet end, and counts samples dropped on overflow.

Parameters:
- DW, 24, sample width in bits.
- AW, 4, FIFO address width; depth is 2**AW = 16 entries.
- PKT_LEN, 256, accepted samples per packet; must be >= 1.
- CW, 16, width of the drop counter.

Ports:
- clk, input, 1, the single clock.
- rst_n, input, 1, synchronous active-low reset.
- en_i, input, 1, capture enable.
- s_data_i, input, DW, sample from the RX interface.
- s_valid_i, input, 1, sample strobe; the source never waits.
- m_data_o, output, DW, FIFO head sample.
- m_last_o, output, 1, head sample is the last of its packet.
- m_valid_o, output, 1, FIFO not empty.
- m_ready_i, input, 1, consumer accepts the head sample.
- ovf_o, output, 1, sticky overflow flag.
- ovf_clr_i, input, 1, clears ovf_o and drop_cnt_o.
- drop_cnt_o, output, CW, saturating count of dropped samples.
- level_o, output, AW+1, current FIFO occupancy, 0..2**AW.

Behaviour:
- Reset: rst_n is sampled on the clk edge only.
  - While low: pointers=0, level_o=0, m_valid_o=0, m_last_o=0, ovf_o=0, drop_cnt_o=0, packet index=0.
  - m_data_o is don't-care.
  - Reset mid-operation discards all buffered data.
- Push request: push = s_valid_i & en_i. When en_i=0 the sample is ignored; it is not counted as dropped.
- Pop: pop = m_valid_o & m_ready_i.
- Full handling: a push is accepted if level<2**AW, or if level==2**AW and pop is high in the same cycle. Simultaneous pop frees the slot.
- Empty handling:
  - Pop with level==0 is impossible, because m_valid_o=0.
  - Push into an empty FIFO goes through storage. There is no bypass.
- Level update: +1 on accepted push without pop, -1 on pop without push, unchanged on both or neither.
- Latency and read mode:
  - A sample accepted at edge N gives m_valid_o=1 from cycle N+1 when the FIFO was empty.
  - The FIFO is first-word-fall-through: m_data_o and m_last_o are read combinationally from the head entry.
  - Head data is stable while m_valid_o=1 and m_ready_i=0.
- Storage: each entry holds DW+1 bits, {last, data}. Pointers are AW bits and wrap modulo 2**AW.
- Packet index:
  - Counts accepted pushes 0..PKT_LEN-1.
  - The stored last bit is 1 when index==PKT_LEN-1; the index then wraps to 0.
  - Dropped samples do not advance the index.
  - When en_i is low the index is forced to 0, so the next capture starts a fresh packet.
  - Entries already buffered keep their tags and drain normally.
- Overflow:
  - A push that is not accepted sets ovf_o=1 and increments drop_cnt_o.
  - drop_cnt_o saturates at 2**CW-1.
  - ovf_clr_i=1 clears both on the next edge.
  - If a drop coincides with ovf_clr_i, the drop wins: ovf_o=1 and drop_cnt_o=1.
- No combinational path from m_ready_i to m_valid_o.

Decomposition:
- Package myriadrf_pkg holds:
  - MYRIADRF_IQ_W=12;
  - MYRIADRF_SAMPLE_W=24;
  - default depth and packet-length constants shared with the RX interface and DMA blocks.
- Sub-module myriadrf_sync_fifo is a generic FWFT storage with pointers and level, parameterised on width and AW.
- The top level adds accept/drop logic, packet tagging and overflow statistics.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles with s_valid_i=1 -> all outputs at reset values; after release with en_i=0 -> level_o stays 0 and drop_cnt_o stays 0.
- Single sample: en_i=1, push 0xABC123 at edge N with m_ready_i=0 -> m_valid_o=1 and m_data_o=0xABC123 in cycle N+1, level_o=1; assert m_ready_i -> empty next cycle.
- Packet tagging: PKT_LEN=4, push 10 samples with m_ready_i=1 -> m_last_o=1 on the 4th and 8th outputs only.
  - Then toggle en_i low for 1 cycle and push 4 more -> m_last_o on the 4th of those.
- Overflow: m_ready_i=0, push 20 samples into 16 entries -> level_o=16, ovf_o=1, drop_cnt_o=4.
  - Drained order is samples 1..16.
  - A 21st push simultaneous with a pop is accepted, not dropped.
- Clear race: with drop_cnt_o=4, assert ovf_clr_i in the same cycle as a drop -> drop_cnt_o=1, ovf_o=1.
  - Next cycle ovf_clr_i alone -> 0, 0.
- Saturation and wrap: CW=3, force 10 drops -> drop_cnt_o=7.
  - Then continuous streaming with random m_ready_i over 100 samples -> the scoreboard sees no loss or reorder across pointer wrap.
